// File: rtl/serial_frame_rx.sv
// Slot-timed serial byte receiver: one bit per 2^SLOT_LOG2-cycle slot,
// LSB first, framed by a single-cycle sync pulse.
module serial_frame_rx #(
  parameter int unsigned SLOT_LOG2 = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sdata,
  input  logic       sync,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  localparam logic [SLOT_LOG2-1:0] CNT_MAX = '1;
  localparam logic [SLOT_LOG2-1:0] CNT_HALF =
    {1'b1, {(SLOT_LOG2-1){1'b0}}};
  localparam logic [SLOT_LOG2-1:0] CNT_ONE =
    {{(SLOT_LOG2-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [SLOT_LOG2-1:0] cnt_q, cnt_d;
  logic [2:0]           slot_q, slot_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  logic in_recv;
  logic sample;
  logic last_cyc;

  assign in_recv  = (state_q == RECV);
  assign sample   = in_recv && (cnt_q == CNT_HALF);
  assign last_cyc = in_recv && (cnt_q == CNT_MAX)
                 && (slot_q == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An early sync keeps us in RECV and wins over frame completion.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (sync) state_d = RECV;
      RECV: if (!sync && last_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = in_recv;
    data_out   = dout_q;
    data_valid = valid_q;
    frame_err  = err_q;
  end

  always_comb begin
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (sync) begin
      cnt_d   = CNT_ONE;
      slot_d  = 3'd0;
      shift_d = 8'h00;
      err_d   = in_recv;
    end else if (in_recv) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_MAX) begin
        slot_d = slot_q + 3'd1;
      end
      if (sample) begin
        shift_d[slot_q] = sdata;
      end
      if (last_cyc) begin
        dout_d  = shift_q;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      slot_q  <= 3'd0;
      shift_q <= 8'h00;
      dout_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx with SLOT_LOG2 = 3 (8-cycle slots,
// 64-cycle frames), checked against a frame-timing model.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sync = 1'b0;
  logic       sdata = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  serial_frame_rx #(.SLOT_LOG2(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .sdata      (sdata),
    .sync       (sync),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  bit   sd [0:19999];

  // Model: a frame started at cycle s completes at the edge ending
  // cycle s+63; bit k is whatever sdata was at cycle s+8k+4.
  bit       m_active = 1'b0;
  int       m_start = 0;
  logic [7:0] m_dout = 8'h00;
  bit       m_valid = 1'b0;
  bit       m_err = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic void model_step(bit r, bit s, int c);
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_dout   = 8'h00;
    end else if (s) begin
      m_err    = m_active;
      m_active = 1'b1;
      m_start  = c;
    end else if (m_active && c == m_start + 63) begin
      for (int k = 0; k < 8; k++) m_dout[k] = sd[m_start + 8*k + 4];
      m_valid  = 1'b1;
      m_active = 1'b0;
    end
  endfunction

  task automatic step(bit r, bit s, bit d);
    reset = r;
    sync  = s;
    sdata = d;
    sd[cyc] = d;
    @(posedge clk);
    #1;
    model_step(r, s, cyc);
    cyc++;
    @(negedge clk);
  endtask

  // mode 0: clean, 1: inverted off-sample, 2: random off-sample
  task automatic send_frame(logic [7:0] b, int mode, int i0, int i1);
    for (int i = i0; i < i1; i++) begin
      bit v;
      v = b[i/8];
      if ((i % 8) != 4) begin
        if (mode == 1) v = ~v;
        else if (mode == 2) v = 1'($urandom);
      end
      step(1'b0, i == 0, v);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_active);
      chk("data_valid", data_valid, m_valid);
      chk("frame_err", frame_err, m_err);
      chk("data_out", data_out, m_dout);
    end
  end

  initial begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    chk_en = 1'b1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'($urandom));

    send_frame(8'hA5, 0, 0, 1);
    chk("lit_busy_start", busy, 1'b1);
    send_frame(8'hA5, 0, 1, 64);
    chk("lit_a5_valid", data_valid, 1'b1);
    chk("lit_a5_dout", data_out, 8'hA5);
    chk("lit_a5_busy", busy, 1'b0);

    send_frame(8'h3C, 2, 0, 64);
    chk("lit_3c_valid", data_valid, 1'b1);
    chk("lit_3c_dout", data_out, 8'h3C);
    send_frame(8'hC3, 2, 0, 64);
    chk("lit_c3_valid", data_valid, 1'b1);
    chk("lit_c3_dout", data_out, 8'hC3);
    step(1'b0, 1'b0, 1'b0);

    send_frame(8'hFF, 0, 0, 20);
    send_frame(8'h5A, 0, 0, 1);
    chk("lit_early_err", frame_err, 1'b1);
    send_frame(8'h5A, 0, 1, 64);
    chk("lit_5a_valid", data_valid, 1'b1);
    chk("lit_5a_dout", data_out, 8'h5A);

    send_frame(8'h96, 1, 0, 64);
    chk("lit_96_dout", data_out, 8'h96);

    send_frame(8'h77, 0, 0, 30);
    step(1'b1, 1'b0, 1'b1);
    chk("lit_rst_dout", data_out, 8'h00);
    chk("lit_rst_busy", busy, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'($urandom));
    chk("lit_rst_after", data_out, 8'h00);

    send_frame(8'h81, 0, 0, 64);
    for (int i = 0; i < 200; i++) step(1'b0, 1'b0, 1'(i));
    chk("lit_nosync_dout", data_out, 8'h81);
    chk("lit_nosync_busy", busy, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      int len;
      b = 8'($urandom);
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 63) : 64;
      send_frame(b, $urandom_range(0, 2), 0, len);
      if ($urandom_range(0, 9) == 0) step(1'b1, 1'($urandom), 1'b1);
      for (int g = $urandom_range(0, 3); g > 0; g--)
        step(1'b0, 1'b0, 1'($urandom));
    end
    for (int i = 0; i < 70; i++) step(1'b0, 1'b0, 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 The block SHALL have one parameter: SLOT_LOG2, default 25, log2 of clock cycles per bit slot (slot length SLOT = 2^SLOT_LOG2; SLOT_LOG2 >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port sdata, input, 1 bit: time-multiplexed serial data, same clock domain, bit k of the byte carried during slot k (k = 0..7, LSB first).
REQ-005 The block SHALL have port sync, input, 1 bit: single-cycle pulse marking the first cycle of slot 0 of a frame.
REQ-006 The block SHALL have port data_out, output, 8 bits: last completed byte, registered, held until the next completed frame.
REQ-007 The block SHALL have port data_valid, output, 1 bit: one-cycle pulse when data_out is updated.
REQ-008 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame is aborted by an early sync.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a frame is being received.

Function
REQ-010 The FSM SHALL have two states: IDLE and RECV; busy SHALL equal (state == RECV).
REQ-011 The cycle with sync = 1 SHALL count as cycle 0 of slot 0; a SLOT_LOG2-bit cycle counter SHALL then read 1 in the next cycle.
REQ-012 In IDLE, sync = 1 SHALL move the FSM to RECV with slot index 0 and cycle counter advancing to 1; sync = 0 SHALL leave all state unchanged.
REQ-013 In RECV, the cycle counter SHALL increment every cycle and wrap from SLOT-1 to 0; each wrap SHALL increment the 3-bit slot index.
REQ-014 sdata SHALL be sampled only when the cycle counter equals SLOT/2, into shift-register bit [slot index]; sdata SHALL be ignored in all other cycles.
REQ-015 Bit k SHALL therefore be sampled k*SLOT + SLOT/2 cycles after the sync cycle.
REQ-016 At the clock edge ending cycle SLOT-1 of slot 7, the block SHALL load data_out from the shift register, set data_valid = 1 for the following cycle, and return to IDLE.
REQ-017 Latency SHALL be fixed: data_valid SHALL be high exactly 8*SLOT cycles after the sync cycle.
REQ-018 A sync in the first cycle after completion SHALL start the next frame normally, so back-to-back frames are received without a gap.
REQ-019 A sync while in RECV (early sync) SHALL pulse frame_err for the next cycle, discard the partial byte without updating data_out or asserting data_valid, and restart reception with that cycle as cycle 0 of slot 0.
REQ-020 data_valid and frame_err SHALL never be high in the same cycle, and each SHALL be high for at most one cycle per event.
REQ-021 The shift register SHALL be cleared on entry to slot 0 so that no stale bits survive an aborted frame.

Reset
REQ-022 While reset = 1, the block SHALL set state = IDLE, cycle counter = 0, slot index = 0, shift register = 0, data_out = 8'h00, data_valid = 0, frame_err = 0, and therefore busy = 0.
REQ-023 Reset SHALL take priority over sync and sdata in the same cycle.
REQ-024 A reset asserted mid-frame SHALL discard the frame with no data_valid and no frame_err.

Verification (SLOT_LOG2 = 3: SLOT = 8, sample at counter 4, frame = 64 cycles; sync at cycle T)
REQ-025 Single frame: sdata carries 0xA5 LSB first, one bit per slot -> data_valid = 1 at T+64 only, data_out = 0xA5, busy high from T+1 to T+63.
REQ-026 Back-to-back frames: 0x3C with sync at T, then 0xC3 with sync at T+64 -> data_valid at T+64 (0x3C) and at T+128 (0xC3), frame_err never asserted.
REQ-027 Early sync: sync at T and again at T+20, second frame carrying 0x5A -> frame_err = 1 at T+21, no data_valid at T+64, data_valid at T+84 with data_out = 0x5A.
REQ-028 Off-sample glitches: sdata inverted during cycles 0-3 and 5-7 of every slot, correct value at counter 4, byte 0x96 -> data_out = 0x96.
REQ-029 Reset mid-frame: reset at T+30 for 1 cycle -> data_out = 0x00, busy = 0 from T+31, no data_valid at T+64.
REQ-030 No sync: sdata toggling for 200 cycles -> busy, data_valid and frame_err all stay 0, and data_out is unchanged.
